// File: rtl/vector_slice_unpacker.sv
// Width down-converter: takes one WIDE_W-bit word over valid/ready and emits it
// as WIDE_W/SLICE_W consecutive SLICE_W-bit slices, streaming words back to back.
module vector_slice_unpacker #(
  parameter int WIDE_W    = 8,
  parameter int SLICE_W   = 4,
  parameter bit MSB_FIRST = 1'b1,
  localparam int N        = WIDE_W / SLICE_W,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDE_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic               out_last,
  output logic [IDX_W-1:0]   out_idx
);

  if (((WIDE_W % SLICE_W) != 0) || (N < 2)) begin : g_param_err
    $error("vector_slice_unpacker: WIDE_W must be a multiple of SLICE_W giving at least two slices");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              state_q, state_d;
  logic [WIDE_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [SLICE_W-1:0]  slice_s;
  logic                at_last_s;

  assign at_last_s = (cnt_q == LAST_IDX);

  // State, held word and slice counter; reset drops any partially emitted word
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on input accept, step or retire on slice accept
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          cnt_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (at_last_s) begin
            // last slice leaving: a waiting word is loaded in the same cycle
            if (in_valid) begin
              hold_d  = in_data;
              cnt_d   = '0;
              state_d = SEND;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Slice selection from the held word, forced to zero when nothing is presented
  always_comb begin
    slice_s = '0;
    if (state_q == SEND) begin
      if (MSB_FIRST) begin
        slice_s = hold_q[WIDE_W - 1 - int'(cnt_q) * SLICE_W -: SLICE_W];
      end else begin
        slice_s = hold_q[int'(cnt_q) * SLICE_W +: SLICE_W];
      end
    end else begin
      slice_s = '0;
    end
  end

  assign in_ready  = (state_q == IDLE) | ((state_q == SEND) & out_ready & at_last_s);
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid & at_last_s;
  assign out_idx   = cnt_q;
  assign out_data  = slice_s;

endmodule

// File: tb/tb_vector_slice_unpacker.sv
// Scoreboard bench: three unpacker configurations, a queue-based slice model
// per instance and a negedge monitor that checks every presented slice.
module tb_vector_slice_unpacker;

  localparam int NDUT = 3;
  localparam int SW [NDUT] = '{4, 8, 8};
  localparam int NN [NDUT] = '{2, 4, 4};
  localparam bit MF [NDUT] = '{1'b1, 1'b1, 1'b0};

  typedef struct {
    logic [7:0] data;
    int         idx;
    logic       last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid_a [NDUT];
  logic [31:0] in_data_a  [NDUT];
  logic        fix_rdy    [NDUT];
  logic [2:0]  rnd_rdy;
  logic        rand_mode;
  logic        ordy [NDUT];
  logic        ir   [NDUT];
  logic        ov   [NDUT];
  logic        ol   [NDUT];
  logic [7:0]  od   [NDUT];
  logic [1:0]  oi   [NDUT];
  logic [3:0]  od0;
  logic        oi0;

  exp_t sb [NDUT][$];
  int   n_cmp;
  int   n_bad;

  for (genvar g = 0; g < NDUT; g++) begin : g_rdy
    assign ordy[g] = rand_mode ? rnd_rdy[g] : fix_rdy[g];
  end
  assign od[0] = {4'h0, od0};
  assign oi[0] = {1'b0, oi0};

  vector_slice_unpacker #(.WIDE_W(8), .SLICE_W(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[0]), .in_ready(ir[0]), .in_data(in_data_a[0][7:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
    .out_last(ol[0]), .out_idx(oi0)
  );

  vector_slice_unpacker #(.WIDE_W(32), .SLICE_W(8), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[1]), .in_ready(ir[1]), .in_data(in_data_a[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .out_last(ol[1]), .out_idx(oi[1])
  );

  vector_slice_unpacker #(.WIDE_W(32), .SLICE_W(8), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[2]), .in_ready(ir[2]), .in_data(in_data_a[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
    .out_last(ol[2]), .out_idx(oi[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rnd_rdy <= 3'($urandom);

  task automatic chk(input string nm, input int d, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Reference model: peel slices off the word by base-2^SLICE_W division,
  // then order them most-significant-first or least-significant-first.
  function automatic void push_word(input int d, input logic [31:0] w);
    exp_t   e;
    longint v;
    longint base;
    longint digits [$];
    v    = longint'(w) % (64'd1 << (SW[d] * NN[d]));
    base = 64'd1 << SW[d];
    for (int k = 0; k < NN[d]; k++) begin
      if (MF[d]) digits.push_front(v % base);
      else       digits.push_back(v % base);
      v = v / base;
    end
    for (int k = 0; k < NN[d]; k++) begin
      e.data = 8'(digits[k]);
      e.idx  = k;
      e.last = (k == NN[d] - 1);
      sb[d].push_back(e);
    end
  endfunction

  // Monitor: every presented slice must match the model head; idle must be clean
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < NDUT; d++) begin
        if (ov[d]) begin
          if (sb[d].size() == 0) begin
            chk("unexpected_slice", d, longint'(od[d]), 64'd0);
            chk("unexpected_valid", d, 64'd1, 64'd0);
          end else begin
            chk("data", d, longint'(od[d]), longint'(sb[d][0].data));
            chk("idx", d, longint'(oi[d]), longint'(sb[d][0].idx));
            chk("last", d, longint'(ol[d]), longint'(sb[d][0].last));
            chk("in_ready", d, longint'(ir[d]), longint'(ordy[d] && sb[d][0].last));
            if (ordy[d]) void'(sb[d].pop_front());
          end
        end else begin
          chk("idle_data", d, longint'(od[d]), 64'd0);
          chk("idle_last", d, longint'(ol[d]), 64'd0);
          chk("idle_in_ready", d, longint'(ir[d]), 64'd1);
          chk("bubble_pending", d, longint'(sb[d].size()), 64'd0);
        end
      end
    end
  end

  task automatic send(input int d, input logic [31:0] w);
    int t;
    in_data_a[d]  = w;
    in_valid_a[d] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!ir[d] && t < 300);
    if (!ir[d]) begin
      chk("accept_timeout", d, 64'd0, 64'd1);
    end else begin
      push_word(d, w);
    end
    @(posedge clk);
    #1;
    in_valid_a[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int t;
    t = 0;
    while (sb[d].size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("drain_left", d, longint'(sb[d].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rand_mode = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      in_valid_a[d] = 1'b0;
      in_data_a[d]  = 32'h0;
      fix_rdy[d]    = 1'b1;
    end

    // Reset held two cycles with a word already offered
    rst           = 1'b1;
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 32'h0000_00A5;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 0, longint'(ov[0]), 64'd0);
      chk("rst_out_data", 0, longint'(od[0]), 64'd0);
      chk("rst_out_last", 0, longint'(ol[0]), 64'd0);
      chk("rst_out_idx", 0, longint'(oi[0]), 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 0, longint'(ir[0]), 64'd1);
    push_word(0, 32'h0000_00A5);
    @(posedge clk);
    #1;
    in_valid_a[0] = 1'b0;
    drain(0);

    // Single word at full rate
    send(0, 32'h0000_00E7);
    drain(0);

    // Backpressure on the first slice for three cycles
    fix_rdy[0] = 1'b0;
    send(0, 32'h0000_003C);
    repeat (3) @(posedge clk);
    #1;
    fix_rdy[0] = 1'b1;
    drain(0);

    // Two words streamed back to back
    send(0, 32'h0000_0012);
    send(0, 32'h0000_0034);
    drain(0);

    // Reset after the first slice leaves; the rest of the word is dropped
    send(0, 32'h0000_009B);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    fix_rdy[0] = 1'b0;
    sb[0].delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    fix_rdy[0] = 1'b1;
    send(0, 32'h0000_0056);
    drain(0);

    // Wide configurations, both slice orders
    send(1, 32'hDEAD_BEEF);
    drain(1);
    send(2, 32'hDEAD_BEEF);
    drain(2);

    // Randomized words, gaps and consumer stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(int'($urandom_range(0, NDUT - 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    for (int d = 0; d < NDUT; d++) drain(d);
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
